// File: rtl/prop_sequencer.sv
// Sequences forward (and optionally backward) propagation across a chain of layer blocks.
// Prop pulses are registered and appear two cycles after the preceding done. A stuck layer is reported through err.
module prop_sequencer #(
  parameter int LAYERS  = 3,
  parameter int TIMEOUT = 64,
  parameter int IW      = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic              train,
  input  logic              abort,
  input  logic [LAYERS-1:0] fd_done,
  input  logic [LAYERS-1:0] bk_done,
  output logic [LAYERS-1:0] fd_prop,
  output logic [LAYERS-1:0] bk_prop,
  output logic              busy,
  output logic [IW-1:0]     layer_idx,
  output logic              seq_done,
  output logic              err,
  output logic [IW-1:0]     err_layer,
  output logic              err_dir
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(LAYERS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FD_ISSUE, S_FD_WAIT, S_BK_ISSUE, S_BK_WAIT, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_layer_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_train;
  logic              r_dir_bk;
  logic [LAYERS-1:0] r_fd_prop;
  logic [LAYERS-1:0] r_bk_prop;
  logic [IW-1:0]     r_err_layer;
  logic              r_err_dir;

  state_t            w_state_nxt;
  logic [IW-1:0]     w_idx_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_train_nxt;
  logic              w_fd_set;
  logic              w_bk_set;
  logic              w_seq_done;
  logic              w_err;
  logic [LAYERS-1:0] w_sel;
  logic              w_fd_hit;
  logic              w_bk_hit;
  logic              w_timeout;

  assign w_sel     = LAYERS'(1) << r_layer_idx;
  assign w_fd_hit  = |(fd_done & w_sel);
  assign w_bk_hit  = |(bk_done & w_sel);
  assign w_timeout = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_layer_idx;
    w_cnt_nxt   = r_cnt;
    w_train_nxt = r_train;
    w_fd_set    = 1'b0;
    w_bk_set    = 1'b0;
    w_seq_done  = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_train_nxt = train;
          w_idx_nxt   = '0;
          w_state_nxt = S_FD_ISSUE;
        end
      end
      S_FD_ISSUE: begin
        w_fd_set    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_FD_WAIT;
      end
      S_FD_WAIT: begin
        if (w_fd_hit) begin
          if (r_layer_idx == LAST_IDX) begin
            w_state_nxt = r_train ? S_BK_ISSUE : S_DONE;
          end else begin
            w_idx_nxt   = r_layer_idx + IW'(1);
            w_state_nxt = S_FD_ISSUE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_BK_ISSUE: begin
        w_bk_set    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_BK_WAIT;
      end
      S_BK_WAIT: begin
        if (w_bk_hit) begin
          if (r_layer_idx == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_layer_idx - IW'(1);
            w_state_nxt = S_BK_ISSUE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_seq_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_err       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over everything the sequence would otherwise do this cycle.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = r_layer_idx;
      w_cnt_nxt   = r_cnt;
      w_fd_set    = 1'b0;
      w_bk_set    = 1'b0;
      w_seq_done  = 1'b0;
      w_err       = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_layer_idx <= '0;
      r_cnt       <= '0;
      r_train     <= 1'b0;
      r_dir_bk    <= 1'b0;
      r_fd_prop   <= '0;
      r_bk_prop   <= '0;
      r_err_layer <= '0;
      r_err_dir   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_layer_idx <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_train     <= w_train_nxt;
      r_fd_prop   <= w_fd_set ? w_sel : '0;
      r_bk_prop   <= w_bk_set ? w_sel : '0;
      if (w_fd_set) r_dir_bk <= 1'b0;
      if (w_bk_set) r_dir_bk <= 1'b1;
      if (w_err) begin
        r_err_layer <= r_layer_idx;
        r_err_dir   <= r_dir_bk;
      end
    end
  end

  assign fd_prop   = r_fd_prop & {LAYERS{~abort}};
  assign bk_prop   = r_bk_prop & {LAYERS{~abort}};
  assign busy      = (r_state != S_IDLE);
  assign layer_idx = r_layer_idx;
  assign seq_done  = w_seq_done;
  assign err       = w_err;
  assign err_layer = r_err_layer;
  assign err_dir   = r_err_dir;

endmodule

// File: tb/tb_prop_sequencer.sv
// Bench for prop_sequencer (LAYERS=3, TIMEOUT=8): layer responder plus event scoreboard with cycle stamps.
module tb_prop_sequencer;
  localparam int L = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_in, start, train, abort;
  logic [L-1:0] fd_done, bk_done, fd_prop, bk_prop;
  logic busy, seq_done, err, err_dir;
  logic [1:0] layer_idx, err_layer;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int dly = 1;
  int skip_fd = -1;
  int skip_bk = -1;
  bit noise = 1'b0;
  int exp_code[$], exp_cyc[$], obs_code[$], obs_cyc[$];

  prop_sequencer #(.LAYERS(L), .TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst_in), .start(start), .train(train), .abort(abort),
    .fd_done(fd_done), .bk_done(bk_done), .fd_prop(fd_prop), .bk_prop(bk_prop),
    .busy(busy), .layer_idx(layer_idx), .seq_done(seq_done), .err(err),
    .err_layer(err_layer), .err_dir(err_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: codes 0..2 fd_prop, 4..6 bk_prop, 8 seq_done, 12 err.
  always @(negedge clk) begin
    if (rst_in) begin
      if ((fd_prop | bk_prop) != 0) begin
        vectors++;
        if ($countones(fd_prop | bk_prop) != 1) begin
          miscompares++;
          $display("FAIL onehot_prop: got fd=%b bk=%b want a single bit", fd_prop, bk_prop);
        end
      end
      for (int i = 0; i < L; i++) begin
        if (fd_prop[i] || bk_prop[i]) begin
          obs_code.push_back(fd_prop[i] ? i : 4 + i);
          obs_cyc.push_back(cyc);
          vectors++;
          if (layer_idx !== i[1:0]) begin
            miscompares++;
            $display("FAIL layer_idx_at_prop: got %0d want %0d", layer_idx, i);
          end
        end
      end
      if (seq_done) begin obs_code.push_back(8); obs_cyc.push_back(cyc); end
      if (err) begin obs_code.push_back(12); obs_cyc.push_back(cyc); end
    end
  end

  // Layer responder: done arrives dly cycles after the observed prop pulse.
  initial begin
    int fc, fl, bc, bl;
    fc = 0; fl = 0; bc = 0; bl = 0;
    fd_done = '0; bk_done = '0;
    forever begin
      @(negedge clk);
      fd_done = '0; bk_done = '0;
      if (!rst_in) begin
        fc = 0; bc = 0;
      end else begin
        if (fc > 0) begin
          fc--;
          if (fc == 2 && noise) begin fd_done[(fl + 1) % L] = 1'b1; bk_done[fl] = 1'b1; end
          if (fc == 0) fd_done[fl] = 1'b1;
        end
        if (bc > 0) begin
          bc--;
          if (bc == 0) bk_done[bl] = 1'b1;
        end
        for (int i = 0; i < L; i++) begin
          if (fd_prop[i] && i != skip_fd) begin fc = dly; fl = i; end
          if (bk_prop[i] && i != skip_bk) begin bc = dly; bl = i; end
        end
      end
    end
  end

  task automatic push_ev(input int code, input int c);
    exp_code.push_back(code);
    exp_cyc.push_back(c);
  endtask

  // Expected events of a fault-free sequence started in cycle s; returns the seq_done cycle.
  task automatic push_seq(input int s, input int d, input bit tr, output int t_end);
    int t;
    t = s + 2;
    for (int i = 0; i < L; i++) begin
      push_ev(i, t);
      if (i == L - 1 && !tr) t_end = t + d + 1;
      t += d + 2;
    end
    if (tr) begin
      t -= d + 2;
      t += d + 2;
      for (int i = L - 1; i >= 0; i--) begin
        push_ev(4 + i, t);
        if (i == 0) t_end = t + d + 1;
        t += d + 2;
      end
    end
    if (tr || !tr) push_ev(8, t_end);
  endtask

  task automatic do_start(input bit tr, output int s);
    s = cyc;
    start = 1'b1; train = tr;
    @(negedge clk);
    start = 1'b0; train = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_in = 1'b0; start = 1'b1; train = 1'b1; abort = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({busy, fd_prop, bk_prop, seq_done, err} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b want 0", {busy, fd_prop, bk_prop, seq_done, err});
      end
      vectors++;
      if ({layer_idx, err_layer, err_dir} !== '0) begin
        miscompares++;
        $display("FAIL reset_regs: got %b want 0", {layer_idx, err_layer, err_dir});
      end
      @(negedge clk);
    end
    start = 1'b0; train = 1'b0;
    rst_in = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic test_forward;
    int s, te;
    @(negedge clk);
    dly = 3; skip_fd = -1; skip_bk = -1; noise = 1'b0;
    do_start(1'b0, s);
    push_seq(s, 3, 1'b0, te);
    wait_to(te);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL fwd_busy_at_done: got %b want 1", busy); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL fwd_busy_after_done: got %b want 0", busy); end
    vectors++;
    if (layer_idx !== 2'd2) begin miscompares++; $display("FAIL fwd_idx_retained: got %0d want 2", layer_idx); end
    wait_to(te + 4);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL fwd_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL fwd_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_train;
    int s, te;
    @(negedge clk);
    dly = 1; skip_fd = -1; skip_bk = -1; noise = 1'b0;
    do_start(1'b1, s);
    push_seq(s, 1, 1'b1, te);
    wait_to(te + 4);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL train_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL train_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_boundary;
    int s, te;
    // done on the last counter value wins; wrong-layer and bk noise are ignored
    @(negedge clk);
    dly = TO - 1; skip_fd = -1; skip_bk = -1; noise = 1'b1;
    do_start(1'b0, s);
    push_seq(s, TO - 1, 1'b0, te);
    wait_to(te + 3);
    // one cycle later is a timeout on layer 0
    dly = TO; noise = 1'b0;
    do_start(1'b0, s);
    push_ev(0, s + 2);
    push_ev(12, s + 2 + TO);
    wait_to(s + 3 + TO);
    vectors++;
    if ({err_layer, err_dir} !== 3'b000) begin
      miscompares++; $display("FAIL bnd_err_info: got layer %0d dir %b want 0/0", err_layer, err_dir);
    end
    wait_to(s + TO + 8);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL bnd_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL bnd_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_timeout;
    int s;
    // forward layer 2 never finishes
    @(negedge clk);
    dly = 1; skip_fd = 2; skip_bk = -1; noise = 1'b0;
    do_start(1'b1, s);
    push_ev(0, s + 2); push_ev(1, s + 5); push_ev(2, s + 8);
    push_ev(12, s + 8 + TO);
    wait_to(s + 9 + TO);
    vectors++;
    if ({err_layer, err_dir} !== 3'b100) begin
      miscompares++; $display("FAIL to_fwd_info: got layer %0d dir %b want 2/0", err_layer, err_dir);
    end
    // backward layer 1 never finishes
    skip_fd = -1; skip_bk = 1;
    @(negedge clk);
    do_start(1'b1, s);
    push_ev(0, s + 2); push_ev(1, s + 5); push_ev(2, s + 8);
    push_ev(6, s + 11); push_ev(5, s + 14);
    push_ev(12, s + 14 + TO);
    wait_to(s + 15 + TO);
    vectors++;
    if ({err_layer, err_dir} !== 3'b011) begin
      miscompares++; $display("FAIL to_bk_info: got layer %0d dir %b want 1/1", err_layer, err_dir);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %b want 0", busy); end
    wait_to(s + TO + 20);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL to_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL to_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
    skip_bk = -1;
  endtask

  task automatic test_abort;
    int s;
    @(negedge clk);
    dly = 3; skip_fd = -1; skip_bk = -1; noise = 1'b0;
    do_start(1'b1, s);
    push_ev(0, s + 2); push_ev(1, s + 7);
    wait_to(s + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(s + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    wait_to(s + 15);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_blocks_start: busy=%b want 0", busy); end
    wait_to(s + 24);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL abort_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL abort_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset_mid;
    int s, s2, te;
    @(negedge clk);
    dly = 1; skip_fd = -1; skip_bk = 1; noise = 1'b0;
    do_start(1'b1, s);
    push_ev(0, s + 2); push_ev(1, s + 5); push_ev(2, s + 8);
    push_ev(6, s + 11); push_ev(5, s + 14);
    wait_to(s + 17);
    rst_in = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, fd_prop, bk_prop, seq_done, err, layer_idx} !== '0) begin
      miscompares++; $display("FAIL rstmid_outputs: got %b want 0", {busy, fd_prop, bk_prop, seq_done, err, layer_idx});
    end
    vectors++;
    if ({err_layer, err_dir} !== 3'b000) begin
      miscompares++; $display("FAIL rstmid_err_info: got layer %0d dir %b want 0/0", err_layer, err_dir);
    end
    skip_bk = -1;
    rst_in = 1'b1;
    do_start(1'b1, s2);
    push_seq(s2, 1, 1'b1, te);
    wait_to(te + 4);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL rstmid_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL rstmid_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  task automatic test_back_to_back;
    int s, s2, te, te2;
    @(negedge clk);
    dly = 1; skip_fd = -1; skip_bk = -1; noise = 1'b0;
    do_start(1'b0, s);
    push_seq(s, 1, 1'b0, te);
    wait_to(te + 1);
    vectors++;
    if (layer_idx !== 2'd2) begin miscompares++; $display("FAIL b2b_idx_retained: got %0d want 2", layer_idx); end
    do_start(1'b1, s2);
    push_seq(s2, 1, 1'b1, te2);
    wait_to(te2 + 4);
    vectors++;
    if (obs_code.size() != exp_code.size()) begin
      miscompares++; $display("FAIL b2b_count: got %0d want %0d events", obs_code.size(), exp_code.size());
    end
    while (obs_code.size() > 0 && exp_code.size() > 0) begin
      int oc, ot, ec, et;
      oc = obs_code.pop_front(); ot = obs_cyc.pop_front(); ec = exp_code.pop_front(); et = exp_cyc.pop_front();
      vectors++;
      if (oc != ec || ot != et) begin
        miscompares++; $display("FAIL b2b_event: got code %0d @%0d want code %0d @%0d", oc, ot, ec, et);
      end
    end
    obs_code.delete(); obs_cyc.delete(); exp_code.delete(); exp_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_train();
    test_boundary();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
